// File: rtl/mic_pkg.sv
// Shared types and helpers for the microarchitecture datapath registers.
package mic_pkg;

    localparam int DATA_W_DEFAULT = 32;

    // Widest legal datapath; extend_load works at this width and callers
    // truncate the result to their own DATA_W.
    localparam int LOAD_MAX_W = 64;

    typedef enum logic [1:0] {
        WORD = 2'b00,
        HALF = 2'b01,
        BYTE = 2'b10
    } rd_size_t;

    // Size a memory word for loading into a register. Encoding 2'b11 is
    // treated as a full word, same as WORD.
    function automatic logic [LOAD_MAX_W-1:0] extend_load(
        input logic [LOAD_MAX_W-1:0] data,
        input logic [1:0]            size,
        input logic                  is_signed
    );
        logic [LOAD_MAX_W-1:0] result;
        result = data;
        if (size == HALF) begin
            result = {{(LOAD_MAX_W-16){is_signed & data[15]}}, data[15:0]};
        end else if (size == BYTE) begin
            result = {{(LOAD_MAX_W-8){is_signed & data[7]}}, data[7:0]};
        end
        return result;
    endfunction

endpackage

// File: rtl/mdr_rd_pipe.sv
// Read-token pipeline: one stage per cycle of memory read latency. Each token
// carries the load size and signedness sampled with its READ so the capture
// is extended the way the read asked for, not the way current inputs say.
module mdr_rd_pipe
    import mic_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd_issue,
    input  logic [1:0] rd_size,
    input  logic       rd_signed,
    output logic       cap_valid,
    output logic [1:0] cap_size,
    output logic       cap_signed,
    output logic       busy
);

    logic [RD_LAT-1:0]      valid_q;
    logic [RD_LAT-1:0][1:0] size_q;
    logic [RD_LAT-1:0]      signed_q;

    // Shift tokens toward the capture stage every cycle; reset drops all.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= '0;
            size_q   <= '0;
            signed_q <= '0;
        end else begin
            valid_q[0]  <= rd_issue;
            size_q[0]   <= rd_size;
            signed_q[0] <= rd_signed;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_q[i]  <= valid_q[i-1];
                size_q[i]   <= size_q[i-1];
                signed_q[i] <= signed_q[i-1];
            end
        end
    end

    assign cap_valid  = valid_q[RD_LAT-1];
    assign cap_size   = size_q[RD_LAT-1];
    assign cap_signed = signed_q[RD_LAT-1];
    assign busy       = |valid_q;

endmodule

// File: rtl/mdr_pipe.sv
// Memory data register with pipelined, size-extended memory reads.
// Memory capture has priority over a C-bus load on the same edge.
module mdr_pipe
    import mic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enaOutA,
    input  logic              enaOutB,
    input  logic              enaIn,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [1:0]        rd_size,
    input  logic              rd_signed,
    input  logic [DATA_W-1:0] inputC,
    input  logic [DATA_W-1:0] inMemPrinc,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] outMemPrinc,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              busy,
    output logic              rd_done,
    output logic              hazard
);

    logic              cap_valid;
    logic [1:0]        cap_size;
    logic              cap_signed;
    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] mdr_q;

    mdr_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk        (clk),
        .reset      (reset),
        .rd_issue   (READ),
        .rd_size    (rd_size),
        .rd_signed  (rd_signed),
        .cap_valid  (cap_valid),
        .cap_size   (cap_size),
        .cap_signed (cap_signed),
        .busy       (busy)
    );

    assign load_word = DATA_W'(extend_load(LOAD_MAX_W'(inMemPrinc), cap_size, cap_signed));

    // Register load: memory capture first, then C bus, else hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdr_q <= '0;
        end else if (cap_valid) begin
            mdr_q <= load_word;
        end else if (enaIn) begin
            mdr_q <= inputC;
        end
    end

    // Completion strobe one cycle after each capture; sticky write hazard.
    // A write alongside a new READ also counts, since that read is in flight
    // from this edge on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_done <= 1'b0;
            hazard  <= 1'b0;
        end else begin
            rd_done <= cap_valid;
            hazard  <= hazard | (WRITE & (busy | READ));
        end
    end

    assign A           = enaOutA ? mdr_q : {DATA_W{1'bz}};
    assign B           = enaOutB ? mdr_q : {DATA_W{1'bz}};
    assign outMemPrinc = mdr_q;
    assign mem_rd      = READ & reset;
    assign mem_wr      = WRITE & reset;

endmodule

// File: tb/tb_mdr_pipe.sv
// Directed and random stimulus for mdr_pipe against a queue-based model of
// outstanding reads (each read remembers the edge at which it must land).
module tb_mdr_pipe;

    localparam int DW  = 32;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          enaOutA, enaOutB, enaIn, READ, WRITE, rd_signed;
    logic [1:0]    rd_size;
    logic [DW-1:0] inputC, inMemPrinc;
    wire  [DW-1:0] A, B;
    logic [DW-1:0] outMemPrinc;
    logic          mem_rd, mem_wr, busy, rd_done, hazard;

    mdr_pipe #(.DATA_W(DW), .RD_LAT(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .enaOutA     (enaOutA),
        .enaOutB     (enaOutB),
        .enaIn       (enaIn),
        .READ        (READ),
        .WRITE       (WRITE),
        .rd_size     (rd_size),
        .rd_signed   (rd_signed),
        .inputC      (inputC),
        .inMemPrinc  (inMemPrinc),
        .A           (A),
        .B           (B),
        .outMemPrinc (outMemPrinc),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .busy        (busy),
        .rd_done     (rd_done),
        .hazard      (hazard)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         due;
        logic [1:0] size;
        logic       sg;
    } pend_t;

    pend_t       pend[$];
    int          edge_n = 0;
    logic [31:0] m_reg;
    logic        m_done;
    logic        m_haz;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_ext(input logic [31:0] d, input logic [1:0] sz, input logic sg);
        longint v;
        if (sz == 2'd1) begin
            v = longint'(d) % 65536;
            if (sg && v >= 32768) v = v - 65536;
        end else if (sz == 2'd2) begin
            v = longint'(d) % 256;
            if (sg && v >= 128) v = v - 256;
        end else begin
            v = longint'(d);
        end
        return v[31:0];
    endfunction

    task automatic model_clear();
        pend.delete();
        m_reg  = '0;
        m_done = 1'b0;
        m_haz  = 1'b0;
    endtask

    task automatic model_edge();
        bit in_flight;
        bit cap;
        if (!reset) begin
            model_clear();
        end else begin
            in_flight = (pend.size() != 0);
            cap       = in_flight && (pend[0].due == edge_n);
            if (WRITE && (in_flight || READ)) m_haz = 1'b1;
            m_done = cap;
            if (cap) begin
                m_reg = m_ext(inMemPrinc, pend[0].size, pend[0].sg);
                pend.delete(0);
            end else if (enaIn) begin
                m_reg = inputC;
            end
            if (READ) pend.push_back('{due: edge_n + LAT, size: rd_size, sg: rd_signed});
        end
        edge_n++;
    endtask

    task automatic check_outputs();
        chk("outMemPrinc", outMemPrinc, m_reg);
        chk("busy", busy, pend.size() != 0);
        chk("rd_done", rd_done, m_done);
        chk("hazard", hazard, m_haz);
        chk("mem_rd", mem_rd, READ && reset);
        chk("mem_wr", mem_wr, WRITE && reset);
        if (enaOutA) chk("A_bus", A, m_reg);
        if (enaOutB) chk("B_bus", B, m_reg);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic async_reset_pulse();
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check_outputs();
        #2;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        enaOutA = 0; enaOutB = 0; enaIn = 0; READ = 0; WRITE = 0;
        rd_size = 2'b00; rd_signed = 0; inputC = '0; inMemPrinc = '0;
        model_clear();
        #3;
        check_outputs();
        READ = 1; WRITE = 1;
        #1;
        chk("mem_rd_in_reset", mem_rd, 1'b0);
        chk("mem_wr_in_reset", mem_wr, 1'b0);
        READ = 0; WRITE = 0;
        #8 reset = 1'b1;

        // C-bus load, then drive A only
        enaIn = 1; inputC = 32'h1234_5678;
        step();
        enaIn = 0; enaOutA = 1;
        #1;
        chk("A_after_load", A, 32'h1234_5678);
        chk("B_not_driven", B !== 32'h1234_5678, 1'b1);
        chk("outMem_after_load", outMemPrinc, 32'h1234_5678);
        step();
        enaOutA = 0;

        // single word read
        inMemPrinc = 32'hDEAD_BEEF; READ = 1; rd_size = 2'b00;
        step();
        READ = 0;
        step();
        step();
        chk("busy_before_cap", busy, 1'b1);
        step();
        chk("word_capture", outMemPrinc, 32'hDEAD_BEEF);
        chk("done_after_cap", rd_done, 1'b1);
        chk("busy_after_cap", busy, 1'b0);
        step();
        chk("done_one_cycle", rd_done, 1'b0);

        // back-to-back reads with differing sizes
        READ = 1; rd_size = 2'b10; rd_signed = 1; inMemPrinc = 32'h5555_5555;
        step();
        rd_size = 2'b01; rd_signed = 0;
        step();
        rd_size = 2'b00; rd_signed = 1;
        step();
        READ = 0; rd_size = 2'b10; inMemPrinc = 32'h0000_0080;
        step();
        chk("b2b_byte_signed", outMemPrinc, 32'hFFFF_FF80);
        inMemPrinc = 32'hFFFF_8001;
        step();
        chk("b2b_half_unsigned", outMemPrinc, 32'h0000_8001);
        chk("b2b_done_held", rd_done, 1'b1);
        inMemPrinc = 32'h0000_0007;
        step();
        chk("b2b_word", outMemPrinc, 32'h0000_0007);
        step();

        // capture wins over enaIn
        READ = 1; rd_size = 2'b00;
        step();
        READ = 0;
        step();
        step();
        enaIn = 1; inputC = 32'h1111_1111; inMemPrinc = 32'h2222_2222;
        step();
        chk("cap_over_enaIn", outMemPrinc, 32'h2222_2222);
        enaIn = 0;
        step();

        // write while busy sets sticky hazard
        READ = 1;
        step();
        READ = 0; WRITE = 1;
        step();
        chk("hazard_set", hazard, 1'b1);
        WRITE = 0;
        repeat (4) step();
        chk("hazard_sticky", hazard, 1'b1);
        chk("hazard_idle_busy", busy, 1'b0);
        async_reset_pulse();
        chk("hazard_cleared", hazard, 1'b0);

        // READ and WRITE together from idle
        READ = 1; WRITE = 1;
        step();
        chk("rw_same_edge_hazard", hazard, 1'b1);
        READ = 0; WRITE = 0;
        repeat (4) step();
        async_reset_pulse();

        // reset in the middle of a read discards it
        READ = 1; inMemPrinc = 32'hCAFE_F00D;
        step();
        READ = 0;
        step();
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check_outputs();
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_capture", outMemPrinc, 32'h0);
            chk("rst_no_done", rd_done, 1'b0);
            chk("rst_not_busy", busy, 1'b0);
        end

        // random traffic
        for (int i = 0; i < 300; i++) begin
            READ       = 1'($urandom_range(0, 1));
            WRITE      = ($urandom_range(0, 7) == 0);
            rd_size    = 2'($urandom_range(0, 3));
            rd_signed  = 1'($urandom_range(0, 1));
            enaIn      = 1'($urandom_range(0, 1));
            enaOutA    = 1'($urandom_range(0, 1));
            enaOutB    = 1'($urandom_range(0, 1));
            inputC     = $urandom;
            inMemPrinc = $urandom;
            step();
            if (i % 60 == 59) async_reset_pulse();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
